// File: rtl/bz_sound_pkg.sv
// Shared definitions for the Battlezone sound control path: latch bit map,
// trigger counter width, default parameters and a small edge-detect helper.
package bz_sound_pkg;

    // Bit positions inside the CPU sound control latch
    localparam int SND_EXPLO_LS   = 0;  // explosion loud(1)/soft(0)
    localparam int SND_EXPLO_REQ  = 1;  // explosion one-shot request
    localparam int SND_SHELL_LS   = 2;  // shell loud(1)/soft(0)
    localparam int SND_SHELL_REQ  = 3;  // shell one-shot request
    localparam int SND_ENGINE_REV = 4;  // engine high-rev select
    localparam int SND_ON         = 5;  // master sound enable
    localparam int SND_SPARE      = 6;  // unused, stored and read back
    localparam int SND_MOTOR      = 7;  // engine sound enable

    // Trigger down-counter width
    localparam int TRIG_W = 8;

    // Defaults for the top-level parameters
    localparam logic [15:0]       LATCH_ADDR_DEFAULT = 16'h1840;
    localparam logic [TRIG_W-1:0] TRIG_TICKS_DEFAULT = 8'd48;

    // A request "rises" when the written byte sets the bit while the stored
    // byte has it clear. The written byte must also carry snd_on, so a write
    // that turns sound on and raises a request in one go still fires.
    function automatic logic req_rise(input logic [7:0] old_latch,
                                      input logic [7:0] new_data,
                                      input int         req_bit);
        return new_data[req_bit] && !old_latch[req_bit] && new_data[SND_ON];
    endfunction

endpackage

// File: rtl/sound_trigger_stretch.sv
// One trigger channel: stretches a single-cycle request edge into a pulse
// lasting TRIG_TICKS clock-enable ticks. Retrigger reloads; a cleared request
// never truncates a pulse already running.
module sound_trigger_stretch
    import bz_sound_pkg::*;
#(
    parameter logic [TRIG_W-1:0] TRIG_TICKS = TRIG_TICKS_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,    // 3 MHz clock enable
    input  logic rise,    // request edge, already qualified by the new snd_on
    input  logic enable,  // stored master sound enable
    output logic pulse
);

    logic [TRIG_W-1:0] r_count;

    // Down-counter: load beats hold-at-zero beats decrement, so a load that
    // lands on a tick starts at the full TRIG_TICKS.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples pre-edge values regardless of block evaluation order.
        if (!rst_n) begin
            r_count <= '0;
        end else if (rise) begin
            r_count <= TRIG_TICKS;
        end else if (!enable) begin
            r_count <= '0;
        end else if (tick && (r_count != '0)) begin
            r_count <= r_count - TRIG_W'(1);
        end
    end

    // Single AND of registered terms: no combinational path from the CPU bus.
    assign pulse = (r_count != '0) && enable;

endmodule

// File: rtl/sound_ctrl_latch.sv
// CPU-side sound control latch. Decodes 6502 writes at LATCH_ADDR, holds the
// control byte, gates the level outputs with snd_on and drives two trigger
// stretchers for the shell and explosion noise channels.
module sound_ctrl_latch
    import bz_sound_pkg::*;
#(
    parameter logic [15:0]       LATCH_ADDR = LATCH_ADDR_DEFAULT,
    parameter logic [TRIG_W-1:0] TRIG_TICKS = TRIG_TICKS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_3MHz_en,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data,
    input  logic        cpu_we,
    output logic [7:0]  cpu_rdata,
    output logic        motor_en,
    output logic        engine_rev_en,
    output logic        shell_ls,
    output logic        shell_en,
    output logic        explo_ls,
    output logic        explo_en
);

    logic [7:0] r_latch;
    logic       w_write;
    logic       w_snd_on;
    logic       w_shell_rise;
    logic       w_explo_rise;

    assign w_write  = cpu_we && (cpu_addr == LATCH_ADDR);
    assign w_snd_on = r_latch[SND_ON];

    // Edge detection compares the incoming byte against the stored byte, so
    // back-to-back writes see the value taken on the previous edge.
    assign w_shell_rise = w_write && req_rise(r_latch, cpu_data, SND_SHELL_REQ);
    assign w_explo_rise = w_write && req_rise(r_latch, cpu_data, SND_EXPLO_REQ);

    // Control latch: loaded on a decoded write, updated even while muted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_latch <= 8'h00;
        end else if (w_write) begin
            r_latch <= cpu_data;
        end
    end

    assign cpu_rdata = r_latch;

    // Level outputs: stored bit gated by the stored master enable.
    assign motor_en      = r_latch[SND_MOTOR]      && w_snd_on;
    assign engine_rev_en = r_latch[SND_ENGINE_REV] && w_snd_on;
    assign shell_ls      = r_latch[SND_SHELL_LS]   && w_snd_on;
    assign explo_ls      = r_latch[SND_EXPLO_LS]   && w_snd_on;

    sound_trigger_stretch #(
        .TRIG_TICKS (TRIG_TICKS)
    ) u_shell_trig (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (clk_3MHz_en),
        .rise   (w_shell_rise),
        .enable (w_snd_on),
        .pulse  (shell_en)
    );

    sound_trigger_stretch #(
        .TRIG_TICKS (TRIG_TICKS)
    ) u_explo_trig (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (clk_3MHz_en),
        .rise   (w_explo_rise),
        .enable (w_snd_on),
        .pulse  (explo_en)
    );

endmodule

// File: tb/tb_sound_ctrl_latch.sv
// Self-checking bench for sound_ctrl_latch: directed scenarios followed by a
// randomized run, all compared every cycle against a behavioural model that
// tracks "elapsed ticks since the pulse started" per trigger channel.
module tb_sound_ctrl_latch;

    localparam int          TRIG = 48;
    localparam logic [15:0] ADDR = 16'h1840;

    logic        clk;
    logic        rst_n;
    logic        clk_3MHz_en;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_we;
    logic [7:0]  cpu_rdata;
    logic        motor_en;
    logic        engine_rev_en;
    logic        shell_ls;
    logic        shell_en;
    logic        explo_ls;
    logic        explo_en;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int s_ticks = 0;   // ticks seen while shell_en was high
    int e_ticks = 0;   // ticks seen while explo_en was high

    // Reference model state
    logic [7:0] m_latch;
    bit         m_s_act, m_e_act;
    int         m_s_el,  m_e_el;

    sound_ctrl_latch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clk_3MHz_en   (clk_3MHz_en),
        .cpu_addr      (cpu_addr),
        .cpu_data      (cpu_data),
        .cpu_we        (cpu_we),
        .cpu_rdata     (cpu_rdata),
        .motor_en      (motor_en),
        .engine_rev_en (engine_rev_en),
        .shell_ls      (shell_ls),
        .shell_en      (shell_en),
        .explo_ls      (explo_ls),
        .explo_en      (explo_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_latch = 8'h00;
        m_s_act = 0; m_s_el = 0;
        m_e_act = 0; m_e_el = 0;
    endtask

    // A pulse is "active" from its start until TRIG ticks have elapsed; a
    // fresh start restarts the elapsed count; muting kills it.
    task automatic model_chan(input bit start, input bit t, input bit on,
                              inout bit act, inout int el);
        if (start) begin
            act = 1; el = 0;
        end else if (!on) begin
            act = 0;
        end else if (act && t) begin
            el++;
            if (el >= TRIG) act = 0;
        end
    endtask

    task automatic model_clock(input logic we, input logic [15:0] addr,
                               input logic [7:0] data, input bit t);
        bit wr, on_now, s_start, e_start;
        wr      = we && (addr == ADDR);
        on_now  = m_latch[5];
        s_start = wr && data[5] && data[3] && !m_latch[3];
        e_start = wr && data[5] && data[1] && !m_latch[1];
        model_chan(s_start, t, on_now, m_s_act, m_s_el);
        model_chan(e_start, t, on_now, m_e_act, m_e_el);
        if (wr) m_latch = data;
    endtask

    function automatic logic [7:0] pack_outs();
        return {2'b00, motor_en, engine_rev_en, shell_ls, shell_en, explo_ls, explo_en};
    endfunction

    function automatic logic [7:0] model_outs();
        bit on;
        on = m_latch[5];
        return {2'b00, m_latch[7] & on, m_latch[4] & on, m_latch[2] & on,
                m_s_act & on, m_latch[0] & on, m_e_act & on};
    endfunction

    task automatic check_outputs();
        check("rdata", cpu_rdata, m_latch);
        check("outs", pack_outs(), model_outs());
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic step(input logic we, input logic [15:0] addr, input logic [7:0] data);
        bit t;
        t = (cyc % 4 == 3);
        cpu_we = we; cpu_addr = addr; cpu_data = data; clk_3MHz_en = t;
        if (t && shell_en) s_ticks++;
        if (t && explo_en) e_ticks++;
        @(posedge clk);
        model_clock(we, addr, data, t);
        cyc++;
        @(negedge clk);
        cpu_we = 1'b0; clk_3MHz_en = 1'b0;
        check_outputs();
    endtask

    task automatic wr(input logic [7:0] data);
        step(1'b1, ADDR, data);
    endtask

    task automatic idle();
        step(1'b0, 16'h0000, 8'h00);
    endtask

    task automatic run_until_idle(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (!shell_en && !explo_en) break;
            idle();
        end
        check("pulse_timeout", {6'd0, shell_en, explo_en}, 8'h00);
    endtask

    task automatic wait_s_ticks(input int n);
        for (int i = 0; i < 1000; i++) begin
            if (s_ticks >= n) break;
            idle();
        end
        check("wait_shell_ticks", 8'(s_ticks >= n), 8'h01);
    endtask

    initial begin
        int  r0;
        bit  seen;
        logic [7:0] d;

        rst_n = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_data = '0; clk_3MHz_en = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_outputs();
        check("reset_rdata", cpu_rdata, 8'h00);

        // Readback and level outputs
        wr(8'hA4);
        check("a4_rdata", cpu_rdata, 8'hA4);
        check("a4_levels", {4'd0, motor_en, shell_ls, engine_rev_en, shell_en}, 8'h0C);

        // Shell pulse with a non-extending rewrite mid-pulse
        s_ticks = 0;
        wr(8'h28);
        check("shell_start", {7'd0, shell_en}, 8'h01);
        wait_s_ticks(20);
        wr(8'h28);
        run_until_idle(400);
        check("shell_len", 8'(s_ticks), 8'(TRIG));

        // Retrigger at tick 30 extends to 48 ticks after the reload
        wr(8'h20);
        s_ticks = 0;
        wr(8'h28);
        wait_s_ticks(30);
        wr(8'h20);
        wr(8'h28);
        r0 = s_ticks;
        run_until_idle(400);
        check("retrig_len", 8'(s_ticks - r0), 8'(TRIG));

        // Clearing the request never truncates the pulse
        wr(8'h20);
        e_ticks = 0;
        wr(8'h22);
        for (int i = 0; i < 50 && e_ticks < 2; i++) idle();
        wr(8'h20);
        run_until_idle(400);
        check("explo_len", 8'(e_ticks), 8'(TRIG));

        // Master mute
        wr(8'h20);
        s_ticks = 0;
        wr(8'h28);
        wait_s_ticks(10);
        wr(8'h08);
        check("mute_outs", pack_outs(), 8'h00);
        check("mute_rdata", cpu_rdata, 8'h08);
        wr(8'h28);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            idle();
            seen |= shell_en;
        end
        check("no_edge_no_pulse", 8'(seen), 8'h00);
        wr(8'h20);
        s_ticks = 0;
        wr(8'h28);
        run_until_idle(400);
        check("unmute_len", 8'(s_ticks), 8'(TRIG));

        // Address decode
        step(1'b1, 16'h1841, 8'hFF);
        check("addr_decode", cpu_rdata, 8'h28);

        // Load coincident with a tick: full length
        wr(8'h20);
        while (cyc % 4 != 3) idle();
        s_ticks = 0;
        wr(8'h28);
        run_until_idle(400);
        check("collision_len", 8'(s_ticks), 8'(TRIG));

        // Asynchronous reset mid-pulse
        wr(8'h20);
        wr(8'h28);
        repeat (10) idle();
        #2 rst_n = 1'b0;
        #1;
        check("arst_shell_en", {7'd0, shell_en}, 8'h00);
        check("arst_rdata", cpu_rdata, 8'h00);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs();

        // snd_on 0->1 together with the request edge fires
        s_ticks = 0;
        wr(8'h28);
        run_until_idle(400);
        check("on_with_edge_len", 8'(s_ticks), 8'(TRIG));

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r0 = int'($urandom_range(0, 15));
            d  = 8'($urandom);
            if ($urandom_range(0, 9) < 8) d[5] = 1'b1;
            if (r0 < 2)       wr(d);
            else if (r0 == 2) step(1'b1, ADDR ^ (16'h1 << $urandom_range(0, 15)), d);
            else              idle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
